femto8_bus_target: RTL and testbench

// - Responder side of the femto8 CPU memory bus: decodes address_bus/write_enable, returns to_cpu.
// - Provides 128B RAM, 128B program ROM with external load port, and a small I/O window.
// - I/O window: output byte FIFO, input holding register, optional prescaled timer.
// - Sits beside the CPU in the top level, replacing the ad-hoc ram/rom arrays.

---
 rtl/femto8_bus_target.sv | 242 ++++++++++++++++++++++++
 tb/tb_femto8_bus_target.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/femto8_bus_target.sv
// femto8_bus_target
// Responder side of the femto8 CPU memory bus. It decodes address_bus and
// write_enable, and returns read data on to_cpu.
//
// Memory map
//   0x00-0x07  RAM
//   0x08-0x0F  I/O window: TXDATA, STATUS, RXDATA, RXACK, TIMER, PRESCALE
//   0x10-0x7F  RAM
//   0x80-0xFF  program ROM; the CPU cannot write it, the external loader can
//
// Optional feature macro: FEMTO8_TIMER_EN
//   Defined   : TIMER/PRESCALE registers and STATUS.wrap are built.
//   Undefined : 0x0C/0x0D read 0x00, writes to them are ignored, STATUS bit4 = 0.
//
// Ports
//   clk, reset                       system clock; synchronous active-low reset
//   address_bus, from_cpu,           CPU address, write data and write strobe
//   write_enable
//   to_cpu                           combinational read data
//   rom_we, rom_addr, rom_wdata      external ROM loader (rom_addr maps to 0x80+)
//   out_data, out_valid, out_ready   output byte FIFO, valid/ready handshake
//   in_data, in_valid, in_ready      input holding register, valid/ready handshake
module femto8_bus_target #(
  parameter int         TX_DEPTH       = 4,
  parameter logic [7:0] PRESCALE_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address_bus,
  input  logic [7:0] from_cpu,
  input  logic       write_enable,
  output logic [7:0] to_cpu,
  input  logic       rom_we,
  input  logic [6:0] rom_addr,
  input  logic [7:0] rom_wdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam int              PW      = $clog2(TX_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(TX_DEPTH);

  logic [7:0] ram [128];
  logic [7:0] rom [128];

  logic       io_sel;
  logic       io_wr;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_rxack;

  logic [7:0]    tx_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] tx_count_next;
  logic          out_valid_q;
  logic          tx_full;
  logic          tx_empty;
  logic          push;
  logic          pop;
  logic          ovf;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       capture;

  logic [7:0] timer_val;
  logic [7:0] prescale_val;
  logic       wrap_flag;
  logic [7:0] status;

  // The I/O window is the 8-byte hole at 0x08-0x0F inside the RAM half.
  assign io_sel    = (address_bus[7:3] == 5'b00001);
  assign io_wr     = write_enable & io_sel;
  assign wr_txdata = io_wr & (address_bus[2:0] == 3'd0);
  assign wr_status = io_wr & (address_bus[2:0] == 3'd1);
  assign wr_rxack  = io_wr & (address_bus[2:0] == 3'd3);

  // RAM and ROM are plain arrays with no reset so their contents survive it.
  // The RAM index is simply the low 7 address bits; entries 8..15 are shadowed
  // by the I/O window and never written.
  always_ff @(posedge clk) begin
    if (write_enable && !address_bus[7] && !io_sel) begin
      ram[address_bus[6:0]] <= from_cpu;
    end
    if (rom_we) begin
      rom[rom_addr] <= rom_wdata;
    end
  end

  // A push into a full FIFO is still accepted when a pop frees a slot in the
  // same cycle; otherwise the byte is dropped and flagged as overflow.
  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign pop      = out_valid_q & out_ready;
  assign push     = wr_txdata & (~tx_full | pop);
  assign out_data  = tx_mem[rd_ptr];
  assign out_valid = out_valid_q;

  always_comb begin
    tx_count_next = tx_count;
    if (push && !pop) begin
      tx_count_next = tx_count + CW'(1);
    end else if (pop && !push) begin
      tx_count_next = tx_count - CW'(1);
    end
  end

  // FIFO storage is gated by reset so a push in the reset cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      tx_mem[wr_ptr] <= from_cpu;
    end
  end

  // FIFO pointers, occupancy and overflow flag. out_valid is registered from the
  // next occupancy so it always matches count!=0 without a cycle of lag.
  // If an overflow and a STATUS write could ever coincide the set wins, so an
  // event is never silently lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_count    <= '0;
      out_valid_q <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      tx_count    <= tx_count_next;
      out_valid_q <= (tx_count_next != '0);
      if (wr_txdata && !push) begin
        ovf <= 1'b1;
      end else if (wr_status) begin
        ovf <= 1'b0;
      end
    end
  end

  // Input holding register: capture only while empty, so capture and RXACK
  // can never target the same cycle's state.
  assign in_ready = ~rx_valid;
  assign capture  = in_valid & ~rx_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      if (capture) begin
        rx_valid <= 1'b1;
        rx_data  <= in_data;
      end else if (wr_rxack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef FEMTO8_TIMER_EN
  logic       wr_timer;
  logic       wr_prescale;
  logic [7:0] timer_q;
  logic [7:0] prescale_q;
  logic [7:0] psc_cnt;
  logic       wrap_q;
  logic       tick;

  assign wr_timer    = io_wr & (address_bus[2:0] == 3'd4);
  assign wr_prescale = io_wr & (address_bus[2:0] == 3'd5);
  assign tick        = (psc_cnt == prescale_q);

  // Prescaler counts 0..PRESCALE and ticks TIMER on the terminal count. Lowering
  // PRESCALE below the current count makes it run on through 0xFF before the
  // next tick, which falls out of the plain 8-bit increment. A TIMER load beats
  // a same-cycle tick and restarts the prescaler.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q    <= 8'h00;
      prescale_q <= PRESCALE_RESET;
      psc_cnt    <= 8'h00;
      wrap_q     <= 1'b0;
    end else begin
      if (wr_timer) begin
        timer_q <= from_cpu;
        psc_cnt <= 8'h00;
      end else if (tick) begin
        timer_q <= timer_q + 8'd1;
        psc_cnt <= 8'h00;
      end else begin
        psc_cnt <= psc_cnt + 8'd1;
      end
      if (wr_prescale) begin
        prescale_q <= from_cpu;
      end
      if (!wr_timer && tick && (timer_q == 8'hFF)) begin
        wrap_q <= 1'b1;
      end else if (wr_status) begin
        wrap_q <= 1'b0;
      end
    end
  end

  assign timer_val    = timer_q;
  assign prescale_val = prescale_q;
  assign wrap_flag    = wrap_q;
`else
  assign timer_val    = 8'h00;
  assign prescale_val = 8'h00;
  assign wrap_flag    = 1'b0;
`endif

  assign status = {3'b000, wrap_flag, ovf, rx_valid, tx_full, tx_empty};

  // Reads are purely combinational and have no side effects.
  always_comb begin
    to_cpu = 8'h00;
    if (address_bus[7]) begin
      to_cpu = rom[address_bus[6:0]];
    end else if (io_sel) begin
      case (address_bus[2:0])
        3'd1:    to_cpu = status;
        3'd2:    to_cpu = rx_data;
        3'd4:    to_cpu = timer_val;
        3'd5:    to_cpu = prescale_val;
        default: to_cpu = 8'h00;
      endcase
    end else begin
      to_cpu = ram[address_bus[6:0]];
    end
  end

endmodule

// File: tb/tb_femto8_bus_target.sv
// tb_femto8_bus_target
// Directed bench for femto8_bus_target (default TX_DEPTH=4). Bytes expected on
// the output FIFO are queued as they are pushed; a monitor on the falling edge
// pops and compares whenever out_valid & out_ready. Register reads are checked
// directly against hand-computed constants.
module tb_femto8_bus_target;

  logic       clk;
  logic       reset;
  logic [7:0] address_bus;
  logic [7:0] from_cpu;
  logic       write_enable;
  logic [7:0] to_cpu;
  logic       rom_we;
  logic [6:0] rom_addr;
  logic [7:0] rom_wdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] expQ [$];

  femto8_bus_target dut (
    .clk          (clk),
    .reset        (reset),
    .address_bus  (address_bus),
    .from_cpu     (from_cpu),
    .write_enable (write_enable),
    .to_cpu       (to_cpu),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_wdata    (rom_wdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: a pop happens on the next rising edge whenever
  // out_valid & out_ready are high here, so compare the head byte now
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL fifo_pop_unexpected: actual=%02h required=no pop", out_data);
      end else begin
        logic [7:0] want;
        want = expQ.pop_front();
        if (out_data !== want) begin
          mismatched++;
          $display("[TB] FAIL fifo_pop: actual=%02h required=%02h", out_data, want);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%02h required=%02h", name, actual, expected);
    end
  endtask

  // One CPU store; returns 1 ns after the edge that performed it
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    address_bus  = addr;
    from_cpu     = data;
    write_enable = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] addr,
                           input logic [7:0] expected);
    address_bus = addr;
    #1;
    checkOutput(name, to_cpu, expected);
  endtask

  task automatic drainCheck(input int budget);
    int c;
    c = 0;
    while (expQ.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    checkOutput("fifo_drained", 8'(expQ.size()), 8'd0);
  endtask

  initial begin
    address_bus  = 8'h00;
    from_cpu     = 8'h00;
    write_enable = 1'b0;
    rom_we       = 1'b0;
    rom_addr     = 7'h00;
    rom_wdata    = 8'h00;
    out_ready    = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    reset        = 1'b0;

    // Reset held low for two clocks
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
    checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
    readCheck("rst_status", 8'h09, 8'h01);
    readCheck("rst_timer", 8'h0C, 8'h00);

    // ROM loader, RAM write, CPU write to ROM ignored
    @(posedge clk); #1;
    rom_we = 1'b1; rom_addr = 7'h00; rom_wdata = 8'h55;
    @(posedge clk); #1;
    rom_we = 1'b0;
    applyStimulus(8'h10, 8'hAA);
    applyStimulus(8'h07, 8'h3E);
    readCheck("rom_80", 8'h80, 8'h55);
    readCheck("ram_10", 8'h10, 8'hAA);
    readCheck("ram_07", 8'h07, 8'h3E);
    applyStimulus(8'h80, 8'h11);
    readCheck("rom_80_after_cpu_wr", 8'h80, 8'h55);
    readCheck("io_unmapped_0e", 8'h0E, 8'h00);

    // Overfill FIFO: 0x05 dropped, ovf set
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expQ.push_back(8'(i));
      applyStimulus(8'h08, 8'(i));
    end
    readCheck("status_full_ovf", 8'h09, 8'h0A);
    readCheck("txdata_reads_zero", 8'h08, 8'h00);
    out_ready = 1'b1;
    drainCheck(20);
    checkOutput("out_valid_after_drain", 8'(out_valid), 8'd0);
    out_ready = 1'b0;
    readCheck("status_empty_ovf", 8'h09, 8'h09);
    applyStimulus(8'h09, 8'h00);
    readCheck("status_ovf_cleared", 8'h09, 8'h01);

    // Push into a full FIFO while it pops: accepted, no overflow
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(8'h21 + 8'(i));
      applyStimulus(8'h08, 8'h21 + 8'(i));
    end
    readCheck("status_full", 8'h09, 8'h02);
    @(posedge clk); #1;
    expQ.push_back(8'h77);
    address_bus  = 8'h08;
    from_cpu     = 8'h77;
    write_enable = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    write_enable = 1'b0;
    drainCheck(20);
    out_ready = 1'b0;
    readCheck("status_no_ovf", 8'h09, 8'h01);

    // Input holding register
    @(posedge clk); #1;
    in_data = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h99;
    checkOutput("in_ready_full", 8'(in_ready), 8'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    readCheck("rxdata", 8'h0A, 8'h3C);
    readCheck("status_rx_valid", 8'h09, 8'h05);
    applyStimulus(8'h0B, 8'h00);
    checkOutput("in_ready_after_ack", 8'(in_ready), 8'd1);

    // Capture offered during reset is discarded; RAM survives reset
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    checkOutput("in_ready_after_reset", 8'(in_ready), 8'd1);
    readCheck("ram_retained", 8'h10, 8'hAA);

`ifdef FEMTO8_TIMER_EN
    // PRESCALE=2: one TIMER tick every 3 clocks
    applyStimulus(8'h0D, 8'h02);
    readCheck("prescale_rd", 8'h0D, 8'h02);
    applyStimulus(8'h0C, 8'hFE);
    readCheck("timer_loaded", 8'h0C, 8'hFE);
    repeat (3) @(posedge clk);
    #1;
    readCheck("timer_ff", 8'h0C, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    readCheck("timer_wrapped", 8'h0C, 8'h00);
    readCheck("status_wrap", 8'h09, 8'h11);
    applyStimulus(8'h09, 8'h00);
    readCheck("status_wrap_cleared", 8'h09, 8'h01);
`else
    applyStimulus(8'h0C, 8'h12);
    readCheck("timer_absent", 8'h0C, 8'h00);
    applyStimulus(8'h0D, 8'h03);
    readCheck("prescale_absent", 8'h0D, 8'h00);
`endif

    checkOutput("queue_empty_end", 8'(expQ.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
